// File: rtl/spike_fanout_dispatcher.sv
// rtl/spike_fanout_dispatcher.sv - spike capture and CSR fan-out packet dispatcher (optional counters: SPIKE_DISPATCH_STATS_EN)
module spike_fanout_dispatcher #(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = 12,
    parameter int MAX_CONN    = 32,
    parameter int PTR_W       = 6,
    parameter int IDX_W       = 6,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic                   clear,
    input  logic [NUM_NEURONS-1:0] spike_in,
    input  logic                   cfg_we,
    input  logic [1:0]             cfg_sel,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [ADDR_W-1:0]      cfg_data,
    output logic                   cfg_err,
    output logic                   pkt_valid,
    input  logic                   pkt_ready,
    output logic [ADDR_W-1:0]      pkt_src,
    output logic [ADDR_W-1:0]      pkt_dst,
    output logic                   busy
`ifdef SPIKE_DISPATCH_STATS_EN
    ,
    output logic [31:0]            stat_pkts,
    output logic [15:0]            stat_coalesced
`endif
);

    localparam int CUR_W = $clog2(NUM_NEURONS + 1);
    localparam int FA_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W = FA_W + 1;

    typedef enum logic {IDLE, EMIT} state_t;

    // Runtime-programmed tables: neuron addresses, CSR row pointers, destinations
    logic [ADDR_W-1:0]      naddr [NUM_NEURONS];
    logic [PTR_W-1:0]       ptr   [NUM_NEURONS+1];
    logic [ADDR_W-1:0]      dst   [MAX_CONN];

    logic [NUM_NEURONS-1:0] pending;
    state_t                 state, state_nx;
    logic [CUR_W-1:0]       cur;
    logic [PTR_W-1:0]       j, end_ptr;

    logic [2*ADDR_W-1:0]    fifo_mem [FIFO_DEPTH];
    logic [FA_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count;

    logic [NUM_NEURONS-1:0] sel_mask, clr_mask;
    logic [CUR_W-1:0]       sel_idx;
    logic                   sel_found;
    logic [PTR_W-1:0]       sel_start, sel_end;
    logic [ADDR_W-1:0]      cur_naddr, cur_dst;
    logic                   range_ok, fifo_full, push, pop, take;
    logic                   cfg_idle_ok, cfg_range_ok, cfg_accept;

    assign sel_found = |pending;
    assign sel_mask  = pending & (~pending + NUM_NEURONS'(1));
    assign clr_mask  = take ? sel_mask : '0;
    assign range_ok  = (j < end_ptr) && (end_ptr <= PTR_W'(MAX_CONN));
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = (count != '0) && pkt_ready;
    assign pkt_valid = (count != '0);
    assign {pkt_src, pkt_dst} = fifo_mem[rd_ptr];
    assign busy      = sel_found || (state != IDLE) || (count != '0);

    // Encode the lowest pending neuron and fetch the table entries it and the current walk need
    always_comb begin
        sel_idx   = '0;
        sel_start = '0;
        sel_end   = '0;
        cur_naddr = '0;
        cur_dst   = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (sel_mask[i]) begin
                sel_idx   = CUR_W'(i);
                sel_start = ptr[i];
                sel_end   = ptr[i+1];
            end
            if (cur == CUR_W'(i)) cur_naddr = naddr[i];
        end
        for (int k = 0; k < MAX_CONN; k++) begin
            if (j == PTR_W'(k)) cur_dst = dst[k];
        end
    end

    // Walk FSM state register
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_nx;
    end

    // Walk FSM next state: select in IDLE, one push per cycle in EMIT, clear aborts
    always_comb begin
        state_nx = state;
        push     = 1'b0;
        take     = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    take     = 1'b1;
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                if (!range_ok) begin
                    state_nx = IDLE;
                end else if (!fifo_full) begin
                    push = 1'b1;
                    if (j + PTR_W'(1) == end_ptr) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (clear) begin
            state_nx = IDLE;
            push     = 1'b0;
            take     = 1'b0;
        end
    end

    // Current neuron and connection cursor
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cur     <= '0;
            j       <= '0;
            end_ptr <= '0;
        end else if (take) begin
            cur     <= sel_idx;
            j       <= sel_start;
            end_ptr <= sel_end;
        end else if (push) begin
            j       <= j + PTR_W'(1);
        end
    end

    // Pending spikes: OR in new pulses, drop the neuron just selected (a same-cycle spike re-arms it)
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)    pending <= '0;
        else if (clear) pending <= '0;
        else            pending <= (pending & ~clr_mask) | spike_in;
    end

    // Output packet FIFO; pointers wrap naturally since the depth is a power of two
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {cur_naddr, cur_dst};
                wr_ptr           <= wr_ptr + FA_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + FA_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Table writes are only safe with no walk in flight and nothing waiting
    always_comb begin
        cfg_idle_ok = (state == IDLE) && !sel_found && !clear;
        case (cfg_sel)
            2'd0:    cfg_range_ok = int'(cfg_idx) <  NUM_NEURONS;
            2'd1:    cfg_range_ok = int'(cfg_idx) <= NUM_NEURONS;
            2'd2:    cfg_range_ok = int'(cfg_idx) <  MAX_CONN;
            default: cfg_range_ok = 1'b0;
        endcase
        cfg_accept = cfg_we && cfg_idle_ok && cfg_range_ok;
    end

    // Table storage and reject pulse
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < NUM_NEURONS; i++)  naddr[i] <= '0;
            for (int i = 0; i <= NUM_NEURONS; i++) ptr[i]   <= '0;
            for (int k = 0; k < MAX_CONN; k++)     dst[k]   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_accept;
            if (cfg_accept) begin
                for (int i = 0; i < NUM_NEURONS; i++)
                    if (cfg_sel == 2'd0 && cfg_idx == IDX_W'(i)) naddr[i] <= cfg_data;
                for (int i = 0; i <= NUM_NEURONS; i++)
                    if (cfg_sel == 2'd1 && cfg_idx == IDX_W'(i)) ptr[i] <= cfg_data[PTR_W-1:0];
                for (int k = 0; k < MAX_CONN; k++)
                    if (cfg_sel == 2'd2 && cfg_idx == IDX_W'(k)) dst[k] <= cfg_data;
            end
        end
    end

`ifdef SPIKE_DISPATCH_STATS_EN
    logic [NUM_NEURONS-1:0] merged;
    logic [CUR_W-1:0]       merged_cnt;
    logic [16:0]            coal_sum;

    assign merged   = spike_in & pending & ~clr_mask;
    assign coal_sum = {1'b0, stat_coalesced} + 17'(merged_cnt);

    // Number of spikes landing on an already-pending neuron this cycle
    always_comb begin
        merged_cnt = '0;
        for (int i = 0; i < NUM_NEURONS; i++) merged_cnt = merged_cnt + CUR_W'(merged[i]);
    end

    // Saturating packet and coalesce counters; clear leaves them alone
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            stat_pkts      <= '0;
            stat_coalesced <= '0;
        end else begin
            if (pop && stat_pkts != '1) stat_pkts <= stat_pkts + 32'd1;
            if (!clear) stat_coalesced <= coal_sum[16] ? 16'hFFFF : coal_sum[15:0];
        end
    end
`endif

endmodule
